// File: rtl/gfsk_pkg.sv
// Shared definitions for the GFSK symbol shaper.
// - GFSK_CODE_W / GFSK_CODE_MAX / GFSK_CODE_MIN: frequency-code width and rails
//   (f = 2.25 MHz + code * 62.5 kHz).
// - gfsk_state_e: transmit FSM states.
// - gfsk_step_toward(): move a code one LSB toward a target, saturating at it.
package gfsk_pkg;

  localparam int unsigned GFSK_CODE_W = 3;

  localparam logic [GFSK_CODE_W-1:0] GFSK_CODE_MAX = 3'd7;
  localparam logic [GFSK_CODE_W-1:0] GFSK_CODE_MIN = 3'd0;

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StDrain
  } gfsk_state_e;

  function automatic logic [GFSK_CODE_W-1:0] gfsk_step_toward(
    input logic [GFSK_CODE_W-1:0] code,
    input logic [GFSK_CODE_W-1:0] target
  );
    if (code < target) begin
      return code + 1'b1;
    end else if (code > target) begin
      return code - 1'b1;
    end
    return code;
  endfunction

endpackage

// File: rtl/gfsk_ramp.sv
// Linear ramp generator for the GFSK frequency code.
// While run is high, the code moves one LSB toward target every RAMP_STEP_CYCLES
// clocks; while run is low the step counter is held at zero and the code holds.
// Ports:
//   clock      - baseband clock, rising edge
//   resetn     - asynchronous active-low reset
//   run        - ramp cadence enable
//   target     - code the ramp is heading for
//   code       - registered frequency code
//   at_target  - code equals target this cycle
module gfsk_ramp
  import gfsk_pkg::*;
#(
  parameter int unsigned RAMP_STEP_CYCLES = 5
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   run,
  input  logic [GFSK_CODE_W-1:0] target,
  output logic [GFSK_CODE_W-1:0] code,
  output logic                   at_target
);

  localparam int unsigned RampW = (RAMP_STEP_CYCLES > 1) ? $clog2(RAMP_STEP_CYCLES) : 1;
  localparam logic [RampW-1:0] RampLast = RampW'(RAMP_STEP_CYCLES - 1);

  logic [RampW-1:0]       ramp_cnt_q, ramp_cnt_d;
  logic [GFSK_CODE_W-1:0] code_q, code_d;

  always_comb begin
    ramp_cnt_d = '0;
    code_d     = code_q;
    if (run) begin
      if (ramp_cnt_q == RampLast) begin
        ramp_cnt_d = '0;
        code_d     = gfsk_step_toward(code_q, target);
      end else begin
        ramp_cnt_d = ramp_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ramp_cnt_q <= '0;
      code_q     <= GFSK_CODE_MIN;
    end else begin
      ramp_cnt_q <= ramp_cnt_d;
      code_q     <= code_d;
    end
  end

  assign code      = code_q;
  assign at_target = (code_q == target);

endmodule

// File: rtl/gfsk_symbol_shaper.sv
// Transmit-side GFSK shaping stage.
// Payload bytes arrive on a valid/ready handshake and are sent LSB-first, one bit
// per CYCLES_PER_SYMBOL clocks. The 3-bit frequency code is ramped one LSB at a
// time toward 7 (bit 1) or 0 (bit 0) rather than stepped. A second byte may be
// parked in a hold register so consecutive bytes go out without a gap.
// Ports:
//   clock, resetn   - 40 MHz baseband clock, asynchronous active-low reset
//   in_valid/ready  - byte handshake (in_ready is combinational)
//   in_data         - payload byte, bit 0 first
//   tx_abort        - drop the current transmission and ramp down to 0
//   gfsk_out        - registered frequency code
//   busy            - transmitting or draining
//   symbol_strobe   - one-cycle pulse on the last cycle of each symbol
module gfsk_symbol_shaper
  import gfsk_pkg::*;
#(
  parameter int unsigned CYCLES_PER_SYMBOL = 40,
  parameter int unsigned RAMP_STEP_CYCLES  = 5
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_data,
  input  logic                   tx_abort,
  output logic [GFSK_CODE_W-1:0] gfsk_out,
  output logic                   busy,
  output logic                   symbol_strobe
);

  if (7 * RAMP_STEP_CYCLES > CYCLES_PER_SYMBOL) begin : g_param_check
    $error("gfsk_symbol_shaper: a full 0..7 ramp must fit within one symbol");
  end

  localparam int unsigned SymW = (CYCLES_PER_SYMBOL > 1) ? $clog2(CYCLES_PER_SYMBOL) : 1;
  localparam logic [SymW-1:0] SymLast = SymW'(CYCLES_PER_SYMBOL - 1);

  gfsk_state_e      state_q, state_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_valid_q, hold_valid_d;
  // Byte accepted in IDLE: shreg is loaded, ACTIVE starts on the following edge.
  logic             start_q, start_d;
  logic [SymW-1:0]  sym_cnt_q, sym_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic             busy_q, busy_d;
  logic             strobe_q, strobe_d;

  logic                   accept;
  logic                   sym_last;
  logic                   ramp_run;
  logic [GFSK_CODE_W-1:0] ramp_target;
  logic                   ramp_at_target;

  assign in_ready = (state_q != StDrain) && !hold_valid_q;
  assign accept   = in_valid && in_ready;
  assign sym_last = (sym_cnt_q == SymLast);

  // The ramp keeps its cadence across byte boundaries and into DRAIN.
  assign ramp_run    = (state_q != StIdle);
  assign ramp_target = ((state_q == StActive) && shreg_q[bit_idx_q]) ? GFSK_CODE_MAX
                                                                     : GFSK_CODE_MIN;

  gfsk_ramp #(
    .RAMP_STEP_CYCLES(RAMP_STEP_CYCLES)
  ) u_ramp (
    .clock    (clock),
    .resetn   (resetn),
    .run      (ramp_run),
    .target   (ramp_target),
    .code     (gfsk_out),
    .at_target(ramp_at_target)
  );

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    start_d      = start_q;
    sym_cnt_d    = sym_cnt_q;
    bit_idx_d    = bit_idx_q;

    unique case (state_q)
      StIdle: begin
        if (start_q) begin
          state_d   = StActive;
          start_d   = 1'b0;
          sym_cnt_d = '0;
          bit_idx_d = '0;
          // A byte offered while start is pending is queued behind the first one.
          if (accept) begin
            hold_d       = in_data;
            hold_valid_d = 1'b1;
          end
        end else if (accept) begin
          shreg_d = in_data;
          start_d = 1'b1;
        end
      end

      StActive: begin
        if (sym_last) begin
          sym_cnt_d = '0;
          bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          sym_cnt_d = sym_cnt_q + 1'b1;
        end

        if (sym_last && (bit_idx_q == 3'd7)) begin
          if (hold_valid_q) begin
            shreg_d      = hold_q;
            hold_valid_d = 1'b0;
            if (accept) begin
              hold_d       = in_data;
              hold_valid_d = 1'b1;
            end
          end else if (accept) begin
            // Byte arriving on the final edge goes straight into the shifter.
            shreg_d = in_data;
          end else begin
            state_d   = StDrain;
            sym_cnt_d = '0;
            bit_idx_d = '0;
          end
        end else if (accept) begin
          hold_d       = in_data;
          hold_valid_d = 1'b1;
        end

        if (tx_abort) begin
          state_d      = StDrain;
          hold_valid_d = 1'b0;
          sym_cnt_d    = '0;
          bit_idx_d    = '0;
        end
      end

      StDrain: begin
        if (ramp_at_target) begin
          state_d = StIdle;
        end
        if (tx_abort) begin
          hold_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d   = (state_d != StIdle);
    strobe_d = (state_d == StActive) && (sym_cnt_d == SymLast);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      shreg_q      <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      start_q      <= 1'b0;
      sym_cnt_q    <= '0;
      bit_idx_q    <= '0;
      busy_q       <= 1'b0;
      strobe_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      start_q      <= start_d;
      sym_cnt_q    <= sym_cnt_d;
      bit_idx_q    <= bit_idx_d;
      busy_q       <= busy_d;
      strobe_q     <= strobe_d;
    end
  end

  assign busy          = busy_q;
  assign symbol_strobe = strobe_q;

endmodule
